// File: rtl/poly_pkg.sv
// Shared types, ALU op codes and overflow helpers for the Horner evaluator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package poly_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  // Widest vector the overflow helpers accept; W+1 must not exceed this.
  localparam int CHKW = 128;

  // True when the low n bits of v are neither all zero nor all one,
  // i.e. the discarded high part of a product does not match the new sign bit.
  function automatic logic mul_ovf(input logic [CHKW-1:0] v, input int n);
    logic [CHKW-1:0] mask;
    mask = (n >= CHKW) ? '1 : ((CHKW'(1) << n) - CHKW'(1));
    return ((v & mask) != '0) && ((v & mask) != mask);
  endfunction

  // True when the carry-out bit and the sign bit of a W+1 bit sum disagree.
  function automatic logic add_ovf(input logic [1:0] top);
    return top[1] ^ top[0];
  endfunction

endpackage

// File: rtl/poly_alu.sv
// Shared signed add/multiply unit, W-bit truncated result plus overflow flag.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module poly_alu
  import poly_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [2*W-1:0] a_x;
  logic [2*W-1:0] b_x;
  logic [2*W-1:0] prod;
  logic [W:0]     sum;

  // Full-precision signed product and sum, then truncate and flag range loss.
  always_comb begin
    a_x  = {{W{a[W-1]}}, a};
    b_x  = {{W{b[W-1]}}, b};
    prod = a_x * b_x;
    sum  = {a[W-1], a} + {b[W-1], b};
    if (op == OP_MUL) begin
      y   = prod[W-1:0];
      ovf = mul_ovf(CHKW'(prod[2*W-1:W-1]), W + 1);
    end else begin
      y   = sum[W-1:0];
      ovf = add_ovf(sum[W:W-1]);
    end
  end

endmodule

// File: rtl/poly_horner.sv
// Signed polynomial evaluator by Horner's rule on one shared add/multiply ALU.
// Latency: 2N cycles from start acceptance to the one-cycle done pulse.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module poly_horner
  import poly_pkg::*;
#(
  parameter int W  = 16,
  parameter int XW = 8,
  parameter int N  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [XW-1:0]      x,
  input  logic [(N+1)*W-1:0] coef,
  output logic [W-1:0]       result,
  output logic               done,
  output logic               busy,
  output logic               ovf
);

  // idx counts N-1 down to 0; keep at least one bit when N = 1.
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  x_r;
  logic [W-1:0]  acc;
  logic [W-1:0]  coef_r [0:N-1];  // c_N goes straight into acc, never stored
  logic [IW-1:0] idx;
  logic          last;

  logic          alu_op;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_y;
  logic          alu_ovf;

  assign last = (idx == '0);

  // Operand steering: multiply by x in MUL, add the current coefficient otherwise.
  always_comb begin
    alu_op = (state == MUL) ? OP_MUL : OP_ADD;
    alu_b  = (state == MUL) ? x_r : coef_r[idx];
  end

  poly_alu #(.W(W)) u_alu (
    .op  (alu_op),
    .a   (acc),
    .b   (alu_b),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: alternate MUL/ADD until the constant term has been added.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = MUL;
      MUL:  state_nxt = ADD;
      ADD:  state_nxt = last ? DONE : MUL;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are pure state decodes so they are glitch-free and start-independent.
  always_comb begin
    done = (state == DONE);
    busy = (state != IDLE);
  end

  // Datapath: capture operands on acceptance, then accumulate one Horner step per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= '0;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < N; i++) coef_r[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_r <= W'($signed(x));
            for (int i = 0; i < N; i++) coef_r[i] <= coef[i*W +: W];
            acc <= coef[N*W +: W];
            idx <= IDX_TOP;
            ovf <= 1'b0;
          end
        end
        MUL: begin
          acc <= alu_y;
          if (alu_ovf) ovf <= 1'b1;
        end
        ADD: begin
          acc <= alu_y;
          if (alu_ovf) ovf <= 1'b1;
          if (last) result <= alu_y;
          else      idx    <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_horner.sv
// Randomised and directed bench for poly_horner against an arithmetic Horner model.
// Latency: checks done arrives 2N cycles after acceptance and busy spans 2N+1 cycles.
// Backpressure: checks start is ignored while busy and back-to-back spacing of 2N+2.
module tb_poly_horner;

  localparam int W  = 16;
  localparam int XW = 8;
  localparam int N  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [XW-1:0]      x = '0;
  logic [(N+1)*W-1:0] coef = '0;
  logic [W-1:0]       result;
  logic               done;
  logic               busy;
  logic               ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int cycle  = 0;

  poly_horner #(.W(W), .XW(XW), .N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x      (x),
    .coef   (coef),
    .result (result),
    .done   (done),
    .busy   (busy),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reduce an exact integer to its W-bit two's complement value.
  function automatic longint wrap(input longint v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return longint'(t);
  endfunction

  function automatic bit out_of_range(input longint v);
    longint lim;
    lim = longint'(1) << (W - 1);
    return (v < -lim) || (v > lim - 1);
  endfunction

  // p(x) evaluated with exact integers; any intermediate outside W bits sets overflow.
  function automatic void ref_eval(input longint xv, input longint c[0:N],
                                   output longint res, output bit ov);
    longint a;
    longint p;
    a  = c[N];
    ov = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      p = a * xv;
      if (out_of_range(p)) ov = 1'b1;
      a = wrap(p);
      p = a + c[i];
      if (out_of_range(p)) ov = 1'b1;
      a = wrap(p);
    end
    res = a;
  endfunction

  task automatic drive_inputs(input longint xv, input longint c[0:N]);
    x = xv[XW-1:0];
    for (int i = 0; i <= N; i++) coef[i*W +: W] = c[i][W-1:0];
  endtask

  // One full evaluation; with scr set, start/x/coef are disturbed while running.
  task automatic do_eval(input string tag, input longint xv, input longint c[0:N], input bit scr);
    longint exp_res;
    bit     exp_ov;
    int     cyc;
    int     bcnt;
    int     pulses;
    logic [63:0] r;
    ref_eval(xv, c, exp_res, exp_ov);
    @(negedge clk);
    start = 1'b1;
    drive_inputs(xv, c);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      if (scr) begin
        r     = {$urandom, $urandom};
        start = r[63];
        x     = r[XW-1:0];
        coef  = r[(N+1)*W-1:0];
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    if (done && busy) bcnt++;
    check({tag, "_latency"}, cyc, 2 * N);
    check({tag, "_busy_cycles"}, bcnt, 2 * N + 1);
    check({tag, "_result"}, longint'($signed(result)), exp_res);
    check({tag, "_ovf"}, ovf, exp_ov);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_after"}, busy, 0);
    if (scr) begin
      pulses = 0;
      repeat (8) begin
        @(posedge clk);
        #1;
        if (done) pulses++;
      end
      check({tag, "_no_extra_done"}, pulses, 0);
    end
  endtask

  initial begin
    longint c[0:N];
    longint exp_q[3];
    longint xs[3];
    longint cs[3][0:N];
    bit     dummy_ov;
    int     last_done;
    int     cyc;
    logic [31:0] r;

    // Reset values while held in reset.
    #12;
    check("rst_result", result, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    c = '{5, -2, 3};
    do_eval("basic_x4", 4, c, 1'b0);
    do_eval("neg_x", -3, c, 1'b0);
    c = '{0, 0, 1000};
    do_eval("ovf_set", 100, c, 1'b0);
    c = '{0, 0, 1};
    do_eval("ovf_clear", 2, c, 1'b0);
    c = '{5, -2, 3};
    do_eval("disturbed", 4, c, 1'b1);

    // Reset during the second MUL.
    c = '{-7, 9, 11};
    @(negedge clk);
    start = 1'b1;
    drive_inputs(3, c);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_result", result, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_ovf", ovf, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrun_rst_no_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    c = '{7, 1, 0};
    do_eval("after_rst", 5, c, 1'b0);

    // Randomised evaluations: mix of small and full-range coefficients.
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i <= N; i++) begin
        r = $urandom;
        if (k % 2 == 0) c[i] = longint'($urandom_range(0, 40)) - 20;
        else            c[i] = wrap(longint'(r));
      end
      do_eval($sformatf("rand%0d", k), longint'($urandom_range(0, 255)) - 128, c, (k % 4) == 3);
    end

    // start held high: three back-to-back evaluations, inputs changed after each done.
    for (int k = 0; k < 3; k++) begin
      xs[k] = longint'($urandom_range(0, 30)) - 15;
      for (int i = 0; i <= N; i++) cs[k][i] = longint'($urandom_range(0, 60)) - 30;
      ref_eval(xs[k], cs[k], exp_q[k], dummy_ov);
    end
    @(negedge clk);
    start = 1'b1;
    drive_inputs(xs[0], cs[0]);
    last_done = 0;
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      @(posedge clk); #1;
      while (!done && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("b2b%0d_done_seen", k), done, 1);
      check($sformatf("b2b%0d_result", k), longint'($signed(result)), exp_q[k]);
      if (k > 0) check($sformatf("b2b%0d_spacing", k), cycle - last_done, 2 * N + 2);
      last_done = cycle;
      if (k < 2) drive_inputs(xs[k+1], cs[k+1]);
    end
    start = 1'b0;
    repeat (8) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_horner.md
# poly_horner

Parametrised signed polynomial evaluator with its own control unit. Computes p(x) = c_N·x^N + … + c_1·x + c_0 by Horner's rule on one shared add/multiply ALU, with a start/done handshake and a sticky overflow flag. Successor to the fixed-degree operative block driven by an external control block: degree, data width and input width are parameters, and control is internal.

## Interface
Parameters:
- W, 16: data/coefficient/result width, signed two's complement.
- XW, 8: width of input x, signed; XW ≤ W.
- N, 2: polynomial degree; N ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- x  in  XW  evaluation point, signed.
- coef  in  (N+1)·W  coefficients; coef[i·W +: W] = c_i, signed.
- result  out  W  last evaluated p(x), truncated to W bits.
- done  out  1  one-cycle pulse, result valid.
- busy  out  1  high while state ≠ IDLE.
- ovf  out  1  sticky overflow for the current/last evaluation.

## Operation
- States: IDLE, MUL, ADD, DONE.
- IDLE: on an edge with start=1: x_r ← sign-extend(x) to W; coef_r ← coef; acc ← c_N; idx ← N−1; ovf ← 0; → MUL. start=0 stays IDLE.
- MUL: acc ← low W bits of acc·x_r (full 2W signed product); → ADD.
- ADD: acc ← low W bits of acc + coef_r[idx] (W+1-bit signed sum); if idx = 0: result ← new acc, → DONE; else idx ← idx−1, → MUL.
- DONE: done = 1 for this one cycle; → IDLE unconditionally.
- Overflow: in MUL, ovf ← 1 if the upper W+1 product bits are not all equal; in ADD, ovf ← 1 if the sum's two top bits differ. Never cleared except on start acceptance or reset.
- Inputs x and coef are captured at acceptance; later changes do not affect the running evaluation.
- start in MUL/ADD/DONE is ignored (not queued).
- result holds its value until the next ADD with idx = 0; not cleared on start.

## Timing
- Reset (async, immediate): state IDLE; acc, idx, x_r, coef_r, result = 0; done = 0; busy = 0; ovf = 0.
- Acceptance edge E0. Edges E1…E2N execute N MUL/ADD pairs. result updated at E2N; done high between E2N and E2N+1. Latency: 2N cycles from acceptance to done.
- busy high from after E0 through the DONE cycle; low in IDLE.
- Throughput: with start held high, the next acceptance is the first IDLE edge after DONE, so one evaluation every 2N+2 cycles.
- rst_n low mid-evaluation: abort immediately to reset values. No done pulse; result reads 0.
- done and busy are registered-state decodes, glitch-free, with no combinational path from start.

## Structure
- Package poly_pkg: state enum (IDLE, MUL, ADD, DONE); ALU op constants OP_ADD, OP_MUL; overflow-check helper functions.
- Sub-module poly_alu: combinational W-bit signed ALU with op select, truncated W-bit out, and overflow out. Instantiated once and shared by MUL and ADD.
- Top holds the FSM, idx counter (width clog2(N)), and the x_r, coef_r, acc and result registers.

## Test plan
- W=16, XW=8, N=2; c2=3, c1=−2, c0=5, x=4 → result=45, ovf=0, done 4 cycles after acceptance, busy high for 5 cycles.
- Same coefficients, x=−3 → result=38, ovf=0. Checks sign extension of x.
- c2=1000, c1=0, c0=0, x=100 → first MUL overflows, ovf=1 sticky, result=−27008. Next start with c2=1, c1=c0=0, x=2 → ovf clears, result=4.
- start pulsed in MUL/ADD, and x and coef changed mid-run → the original evaluation completes unchanged, with no extra done.
- rst_n asserted during the second MUL → all outputs 0 immediately, no done. After release, start with c2=0, c1=1, c0=7, x=5 → result=12.
- start held high for 3 evaluations → done pulses spaced exactly 6 cycles apart, each with the correct result.
